// File: rtl/jt12_pkg.sv
// jt12_pkg: widths and FSM encoding shared by the jt12 serial output path.
package jt12_pkg;

    localparam int FRAME_W = 32;
    localparam int WORD_W  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } outser_state_t;

endpackage

// File: rtl/jt12_outser_div.sv
// jt12_outser_div: bit clock divider with a strobe on each falling bck edge.
module jt12_outser_div #(
    parameter int BCK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bck,
    output logic fall
);

    localparam logic [7:0] LAST = 8'(BCK_DIV - 1);

    logic [7:0] div_cnt;
    logic       wrap;

    assign wrap = en && (div_cnt == LAST);
    // fall marks the cycle whose edge takes bck from 1 to 0
    assign fall = wrap && bck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bck     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bck     <= ~bck;
        end else if (en) begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/jt12_outser.sv
// jt12_outser: left-justified serial output of jt12 accumulator samples.
// Define JT12_OUTSER_OVF_EN to add the ovf overwrite-detect pulse output.
module jt12_outser
    import jt12_pkg::*;
#(
    parameter int BCK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample,
    input  logic [15:0] left,
    input  logic [15:0] right,
    output logic        bck,
    output logic        lrck,
    output logic        sdata,
    output logic        busy
`ifdef JT12_OUTSER_OVF_EN
    ,
    output logic        ovf
`endif
);

    outser_state_t state, state_nx;

    logic [WORD_W-1:0]  hl, hr;
    logic               hvalid;
    logic [FRAME_W-1:0] sr;
    logic [4:0]         bit_cnt;
    logic               fall;
    logic               start, reload, load, mid;

    assign busy   = (state == ST_RUN);
    assign start  = (state == ST_IDLE) && hvalid;
    assign reload = fall && (bit_cnt == 5'(FRAME_W - 1));
    assign mid    = fall && (bit_cnt == 5'(WORD_W - 1));
    assign load   = start || reload;

    jt12_outser_div #(.BCK_DIV(BCK_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .bck  (bck),
        .fall (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == ST_IDLE && hvalid)
            state_nx = ST_RUN;
    end

    // a strobe in the load cycle wins and keeps hvalid for the next frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hl     <= '0;
            hr     <= '0;
            hvalid <= 1'b0;
        end else if (sample) begin
            hl     <= left;
            hr     <= right;
            hvalid <= 1'b1;
        end else if (load) begin
            hvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            bit_cnt <= '0;
            sdata   <= 1'b0;
            lrck    <= 1'b0;
        end else if (load) begin
            sr      <= {hl, hr};
            bit_cnt <= '0;
            sdata   <= hl[WORD_W-1];
            lrck    <= 1'b0;
        end else if (fall) begin
            sr      <= sr << 1;
            bit_cnt <= bit_cnt + 5'd1;
            sdata   <= sr[FRAME_W-2];
            if (mid) lrck <= 1'b1;
        end
    end

`ifdef JT12_OUTSER_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf <= 1'b0;
        else     ovf <= sample && hvalid && !load;
    end
`endif

endmodule

// File: tb/tb_jt12_outser.sv
// tb_jt12_outser: frame-level scoreboard bench for jt12_outser.
module tb_jt12_outser;

    localparam int BCK_DIV   = 2;
    localparam int FRAME_CYC = 64 * BCK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample = 1'b0;
    logic [15:0] left = '0;
    logic [15:0] right = '0;
    logic        bck, lrck, sdata, busy;
`ifdef JT12_OUTSER_OVF_EN
    logic        ovf;
    logic        exp_ovf = 1'b0;
`endif

    jt12_outser #(.BCK_DIV(BCK_DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .sample (sample),
        .left   (left),
        .right  (right),
        .bck    (bck),
        .lrck   (lrck),
        .sdata  (sdata),
        .busy   (busy)
`ifdef JT12_OUTSER_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // frame-level model: each frame carries whatever the holding
    // register held just before its start edge
    logic [31:0] m_hold;
    logic        m_hvalid;
    logic        m_run;
    int          cyc;
    int          m_next;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hold   = '0;
        m_hvalid = 1'b0;
        m_run    = 1'b0;
        m_next   = 0;
`ifdef JT12_OUTSER_OVF_EN
        exp_ovf  = 1'b0;
`endif
    endtask

    task automatic step(input logic s, input logic [15:0] l,
                        input logic [15:0] r);
        bit ld;
        sample = s;
        left   = l;
        right  = r;
        @(posedge clk);
        ld = (!m_run && m_hvalid) || (m_run && cyc == m_next);
        if (ld) begin
            exp_q.push_back(m_hold);
            m_run  = 1'b1;
            m_next = cyc + FRAME_CYC;
        end
`ifdef JT12_OUTSER_OVF_EN
        exp_ovf = s && m_hvalid && !ld;
`endif
        if (s) begin
            m_hold   = {l, r};
            m_hvalid = 1'b1;
        end else if (ld) begin
            m_hvalid = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0);
    endtask

    // advance until the next step lands on a frame start edge
    task automatic to_reload();
        while (cyc != m_next) step(1'b0, 16'h0, 16'h0);
    endtask

    // monitor: rebuild frames from sdata/lrck on rising bck
    int          mcyc = 0;
    int          last_rise = -1;
    int          frame_start = -1;
    int          nbits = 0;
    logic        pbck = 1'b0;
    logic [31:0] sh = '0;
    logic [31:0] lr = '0;

    always @(negedge clk) begin
        mcyc++;
`ifdef JT12_OUTSER_OVF_EN
        check("ovf", {31'b0, ovf}, {31'b0, exp_ovf});
`endif
        if (rst) begin
            nbits       = 0;
            last_rise   = -1;
            frame_start = -1;
            pbck        = 1'b0;
        end else begin
            if (bck && !pbck) begin
                if (last_rise >= 0)
                    check("bck_period", mcyc - last_rise, 2 * BCK_DIV);
                last_rise = mcyc;
                if (nbits == 0) begin
                    if (frame_start >= 0)
                        check("frame_len", mcyc - frame_start, FRAME_CYC);
                    frame_start = mcyc;
                end
                sh = {sh[30:0], sdata};
                lr = {lr[30:0], lrck};
                nbits++;
                if (nbits == 32) begin
                    nbits = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got %h want none", sh);
                    end else begin
                        check("frame_data", sh, exp_q.pop_front());
                        check("frame_lrck", lr, 32'h0000FFFF);
                    end
                end
            end
            pbck = bck;
        end
    end

    initial begin
        int idle_bad;
        logic [15:0] rl, rr;
        cyc = 0;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {28'b0, busy, bck, lrck, sdata}, 32'h0);
        rst = 1'b0;

        idle_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 16'h0, 16'h0);
            if (busy || bck || sdata) idle_bad++;
        end
        check("idle_quiet", idle_bad, 0);

        step(1'b1, 16'h8001, 16'h7FFE);
        idle(3 * FRAME_CYC);

        to_reload();
        step(1'b0, 16'h0, 16'h0);
        idle(20);
        step(1'b1, 16'h1111, 16'h1111);
        idle(20);
        step(1'b1, 16'h2222, 16'h2222);
        idle(2 * FRAME_CYC);

        to_reload();
        step(1'b1, 16'h0F0F, 16'h0F0F);
        idle(2 * FRAME_CYC);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rl = 16'($urandom);
                rr = 16'($urandom);
                step(1'b1, rl, rr);
            end else begin
                step(1'b0, 16'h0, 16'h0);
            end
        end

        to_reload();
        step(1'b0, 16'h0, 16'h0);
        idle(82);
        rst = 1'b1;
        #1;
        check("rst_mid", {28'b0, busy, bck, lrck, sdata}, 32'h0);
        exp_q.delete();
        model_reset();
        idle(3);
        rst = 1'b0;
        idle(10);
        check("post_rst_idle", {31'b0, busy}, 32'h0);
        rr = 16'($urandom);
        step(1'b1, 16'hAAAA, rr);
        step(1'b0, 16'h0, 16'h0);
        check("restart_first_bit", {29'b0, sdata, lrck, busy}, 32'h5);
        idle(2 * FRAME_CYC + 10);

        check("queue_drain", {31'b0, exp_q.size() <= 1}, 32'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt12_outser.md
JT12_OUTSER -- requirements
Module: jt12_outser

Interface
REQ-001 Parameter BCK_DIV, default 2, meaning clk cycles per bck half-period (legal 1..255).
REQ-002 Port: clk, input, 1, system clock; all state on rising edge.
REQ-003 Port: rst, input, 1, reset; asynchronous, active-high.
REQ-004 Port: sample, input, 1, one-cycle strobe; left/right valid this cycle (driven by accumulator sample-ready).
REQ-005 Port: left, input, 16, signed left sample from jt12_acc.
REQ-006 Port: right, input, 16, signed right sample from jt12_acc.
REQ-007 Port: bck, output, 1, serial bit clock.
REQ-008 Port: lrck, output, 1, word select; 0 = left word, 1 = right word.
REQ-009 Port: sdata, output, 1, serial data, MSB first, left-justified.
REQ-010 Port: busy, output, 1, high in RUN state.

Function
REQ-011 Holding register {hl,hr} plus hvalid flag shall latch left/right on every cycle sample=1.
REQ-012 FSM states IDLE and RUN; IDLE->RUN on the cycle after hvalid first goes high; RUN exits only by reset.
REQ-013 On IDLE->RUN, the block shall load the 32-bit shift register with {hl,hr}, clear hvalid, and set div_cnt=0, bit_cnt=0, bck=0, lrck=0, sdata=hl[15].
REQ-014 In RUN, div_cnt shall count 0..BCK_DIV-1 and toggle bck when div_cnt==BCK_DIV-1, then wrap to 0.
REQ-015 A falling bck edge (1->0 toggle) shall be the only event on which sdata, lrck, bit_cnt and shift register change.
REQ-016 On each falling edge, bit_cnt shall increment mod 32, and the shift register shall shift left one place, with sdata taking the new MSB.
REQ-017 On the falling edge where bit_cnt wraps 31->0, the shift register shall reload from the holding register, lrck shall go 0, and hvalid shall clear.
REQ-018 If hvalid=0 at the reload, the previous frame's {hl,hr} shall be repeated (no zero insertion).
REQ-019 On the falling edge where bit_cnt goes 15->16, lrck shall go 1.
REQ-020 A sample strobe coincident with reload shall win: the new values load into holding and hvalid stays 1 for the next frame; the shift register takes the pre-strobe holding contents.
REQ-021 A second sample strobe before reload shall overwrite the holding register (latest wins).
REQ-022 Frame length shall be 64*BCK_DIV clk cycles.

Reset
REQ-023 During rst the block shall be in IDLE, with bck=0, lrck=0, sdata=0, busy=0, hvalid=0, all counters and registers 0.
REQ-024 Reset asserted mid-frame shall abort the frame immediately (asynchronously); the first frame after release shall start only after a new sample strobe.

Configuration
REQ-025 Macro JT12_OUTSER_OVF_EN defined: add output ovf (1 bit), pulsed high for one cycle when a sample strobe arrives while hvalid=1 and no reload occurs in that same cycle; reset value 0.
REQ-026 Macro undefined: no ovf port; overwrite behaviour per REQ-021 is unchanged.

Structure
REQ-027 Shared package jt12_pkg shall hold the frame width (32), the word width (16), and the FSM state encoding.
REQ-028 Sub-module jt12_outser_div (bck divider and falling-edge strobe) shall be instantiated once; the rest shall be flat.

Verification
REQ-029 Reset, then 1000 cycles with no sample -> busy=0, bck=0, sdata=0 throughout.
REQ-030 BCK_DIV=2, one strobe with left=16'h8001 and right=16'h7FFE -> bck period 4 clk; lrck low for 16 bits then high for 16 bits; sdata bits 1000_0000_0000_0001 then 0111_1111_1111_1110.
REQ-031 No further strobe -> second frame repeats 16'h8001/16'h7FFE exactly; frame length 128 clk.
REQ-032 Two strobes (16'h1111, then 16'h2222) within one frame -> next frame carries 16'h2222; ovf pulses once when the macro is defined.
REQ-033 Strobe with 16'h0F0F in the same cycle as reload -> current frame carries the old data; next frame carries 16'h0F0F; no ovf.
REQ-034 rst asserted at bit 20 of a frame -> all outputs 0 within the same cycle; after release and a strobe with 16'hAAAA, sdata=1 immediately with lrck=0.
